// File: rtl/div_3_arbiter.sv
// div_3_arbiter: round-robin front end sharing one div_3 among requesters.
// Carries requester tags alongside the divider pipeline and stalls on back-pressure.
module div_3_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DIV_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 div_en,
  output logic [7:0]           div_in,
  input  logic [7:0]           div_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data
);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] sel;
  logic            hit;
  logic            stall;
  logic            issue;
  tag_t            nxt_tag;
  tag_t            tags [DIV_LAT];

  assign stall  = rsp_valid & ~rsp_ready;
  assign div_en = rst & ~stall;
  assign issue  = div_en & hit;

  // rotating search for the first active request from the pointer
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

  // one-hot grant and operand mux, both silent while stalled or in reset
  always_comb begin
    gnt    = '0;
    div_in = '0;
    if (issue) gnt[sel] = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) div_in = req_data[8*k +: 8];
    end
  end

  // tag entering the pipeline this edge; a bubble carries id 0
  always_comb begin
    nxt_tag.v  = issue;
    nxt_tag.id = issue ? sel : '0;
  end

  // priority pointer moves past the granted requester
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= ID_W'((int'(sel) + 1) % NUM_REQ);
    end
  end

  // tag pipeline shadows div_3, advancing only on enabled edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIV_LAT; i++) tags[i] <= '0;
    end else if (div_en) begin
      for (int i = DIV_LAT - 1; i > 0; i--) tags[i] <= tags[i-1];
      tags[0] <= nxt_tag;
    end
  end

  assign rsp_valid = tags[DIV_LAT-1].v;
  assign rsp_id    = tags[DIV_LAT-1].id;
  assign rsp_data  = div_out;

endmodule

// File: doc/div_3_arbiter.md
Name: div_3_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one div_3 instance among NUM_REQ requesters.
- Grants at most one request per cycle and drives div_3's en and in.
- Tracks each in-flight operand's requester ID through the div_3 pipeline and returns the quotient tagged with that ID.
- Stalls the shared divider when the consumer back-pressures. Sits between requester blocks and the div_3 datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ.
- DIV_LAT, 1, div_3 latency in enabled clock edges from in to out.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held with data until granted.
- req_data  in  8*NUM_REQ  signed 2.6 fixed-point operands; requester k at bits [8k+7:8k].
- gnt  out  NUM_REQ  one-hot grant, combinational; handshake completes on a clk edge where req[k]&gnt[k].
- div_en  out  1  enable to div_3.
- div_in  out  8  operand to div_3 (signed 2.6).
- div_out  in  8  quotient from div_3 (signed 2.6).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready.
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  8  quotient (signed 2.6).

Behaviour:
- Reset (rst=0, async):
  - Tag pipeline valid bits cleared; rsp_valid=0, rsp_id=0.
  - Priority pointer = 0; gnt=0; div_en=0; div_in=0.
  - Once rst deasserts, the first grant goes to the lowest-index active request at or above index 0.
- Stall:
  - stall = rsp_valid & ~rsp_ready.
  - div_en = ~stall while out of reset.
  - While stalled: gnt=0, the tag pipeline holds, and rsp_id/rsp_data stay stable.
- Arbitration (when not stalled):
  - Search req starting at the priority pointer, wrapping modulo NUM_REQ.
  - gnt = one-hot of the first set bit found; gnt=0 if req=0.
  - On the edge, the pointer moves to (granted index + 1) mod NUM_REQ.
  - With no grant, the pointer is unchanged.
- Issue:
  - div_in = req_data slice of the granted requester; 0 when no grant.
  - An idle slot still clocks div_3 (div_en=1), but carries a bubble (tag valid=0).
- Tag pipeline:
  - Shift register of DIV_LAT entries {valid, id}, advancing on each edge with div_en=1.
  - Stage 0 captures {|gnt, granted id}.
  - The last stage drives rsp_valid and rsp_id; rsp_data = div_out (combinational pass-through, aligned with the last stage).
- Latency: a grant on edge N gives rsp_valid at edge N+DIV_LAT (with no stall), same id and matching quotient.
- Throughput: one operation per cycle with rsp_ready held high.
- A response is consumed on an edge with rsp_valid&rsp_ready. The pipeline advances on that same edge, and a new grant may issue that cycle.
- Simultaneous requests are fair: every active requester is granted within NUM_REQ grants.
- Requests:
  - A requester dropping req before it is granted is not an error; its request is simply not served.
  - req must not change data while req=1 and ungranted.
- Reset mid-operation: in-flight tags are discarded and no response is emitted for them. div_3 is reset by the same rst.
- Arithmetic: no computation inside the arbiter; 8-bit values pass through unchanged. Sign is preserved.

Test Plan:
- Single requester, rsp_ready=1: req[0]=1, data 0x40 (1.0) -> gnt=0001, DIV_LAT edges later rsp_valid=1, rsp_id=0, rsp_data=0x15 (0.328125).
- All four requesting continuously, data 0x60/0xC0/0x30/0x00 -> grants in order 0,1,2,3,0,...; responses in order id 0,1,2,3 with data 0x20, 0xEB, 0x10, 0x00.
- Back-pressure: 3 responses in flight, rsp_ready=0 for 5 cycles -> div_en=0, gnt=0, rsp_id/rsp_data frozen. Release rsp_ready -> remaining responses follow in order with none lost or duplicated.
- Fairness after idle: grant req[2], drop all requests, then raise req[0] and req[3] -> req[3] granted first (pointer=3), then req[0].
- Reset mid-stream: assert rst with 1 response in flight -> rsp_valid=0 immediately (async), gnt=0. After release, no stale response appears; a new request to req[1]=0x40 returns id 1, data 0x15.
- Bubble handling: req toggles 1,0,1 on requester 1 -> responses spaced identically (valid,invalid,valid) with no phantom rsp_valid.
